rom_scan_ctrl: RTL and testbench

//  Address sequencer and read controller that sits directly upstream of the 8-bit

---
 rtl/rom_scan_pkg.sv | 21 ++
 rtl/rom_scan_if.sv | 14 +
 rtl/rom_scan_fifo.sv | 54 +++++
 rtl/rom_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_rom_scan_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_scan_pkg.sv
// Shared definitions for the ROM scan controller: FSM encoding, default sizes
// and the wrapping address step.
package rom_scan_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 11;
  localparam int DEF_FIFO_D = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // The comparison happens before the increment, so a full 2^ADDR_W space wraps cleanly.
  function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned depth);
    return (addr == depth - 1) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/rom_scan_if.sv
// Valid/ready word stream leaving the scan controller.
interface rom_scan_if
  import rom_scan_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/rom_scan_fifo.sv
// Small synchronous FIFO holding ROM words plus their last flag; the head is
// presented combinationally so a freshly written word is visible the next cycle.
module rom_scan_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       empty,
  output logic                       full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] occ_reg;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (occ_reg == '0);
  assign full      = (occ_reg == CNT_W'(DEPTH));
  assign occupancy = occ_reg;
  assign do_pop    = pop && !empty;
  assign head_data = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push)   wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, do_pop})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end
endmodule

// File: rtl/rom_scan_ctrl.sv
// Walks a run of ROM addresses, tracks the two-cycle read latency with a tag pipe
// and streams the words out through a credit-limited buffer.
module rom_scan_ctrl
  import rom_scan_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int FIFO_D = DEF_FIFO_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] count,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  rom_scan_if.master        out_if
);
  localparam int CNT_W = $clog2(FIFO_D + 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] rem_reg, rem_next;
  logic [ADDR_W-1:0] rom_addr_reg, rom_addr_next, issue_addr;
  logic [1:0]        tag_reg, last_tag_reg, in_flight;
  logic              done_reg, done_next, err_reg, err_next;
  logic              issue, issue_last, start_bad, credit_ok, last_xfer;
  logic [CNT_W-1:0]  occupancy;
  logic              fifo_empty, fifo_full;
  logic [DATA_W:0]   head;

  assign start_bad = 32'(start_addr) >= 32'(DEPTH);
  assign in_flight = 2'(tag_reg[0]) + 2'(tag_reg[1]);
  // Pops in the current cycle are deliberately not credited back.
  assign credit_ok = (32'(occupancy) + 32'(in_flight)) < 32'(FIFO_D);
  assign last_xfer = out_if.out_valid && out_if.out_ready && out_if.out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      rem_reg      <= '0;
      rom_addr_reg <= '0;
      tag_reg      <= '0;
      last_tag_reg <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      rem_reg      <= rem_next;
      rom_addr_reg <= rom_addr_next;
      tag_reg      <= {tag_reg[0], issue};
      last_tag_reg <= {last_tag_reg[0], issue_last};
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start && !start_bad && count != '0)
                  state_next = (count == ADDR_W'(1)) ? ST_DRAIN : ST_ISSUE;
      ST_ISSUE: if (credit_ok && rem_reg == ADDR_W'(1)) state_next = ST_DRAIN;
      ST_DRAIN: if (last_xfer) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // The first read goes out on the accepting edge, so IDLE issues too.
  always_comb begin
    issue         = 1'b0;
    issue_last    = 1'b0;
    issue_addr    = addr_reg;
    addr_next     = addr_reg;
    rem_next      = rem_reg;
    rom_addr_next = rom_addr_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;
    case (state_reg)
      ST_IDLE: if (start) begin
        if (start_bad) err_next = 1'b1;
        else if (count == '0) done_next = 1'b1;
        else begin
          issue      = 1'b1;
          issue_addr = start_addr;
          issue_last = (count == ADDR_W'(1));
          rem_next   = count - 1'b1;
        end
      end
      ST_ISSUE: if (credit_ok) begin
        issue      = 1'b1;
        issue_last = (rem_reg == ADDR_W'(1));
        rem_next   = rem_reg - 1'b1;
      end
      ST_DRAIN: done_next = last_xfer;
      default: ;
    endcase
    if (issue) begin
      rom_addr_next = issue_addr;
      addr_next     = ADDR_W'(wrap_inc(32'(issue_addr), 32'(DEPTH)));
    end
  end

  rom_scan_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tag_reg[1]),
    .push_data ({last_tag_reg[1], rom_data}),
    .pop       (out_if.out_valid && out_if.out_ready),
    .head_data (head),
    .occupancy (occupancy),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assert property (@(posedge clk) disable iff (!rst_n) !(tag_reg[1] && fifo_full));

  assign rom_addr         = rom_addr_reg;
  assign busy             = (state_reg != ST_IDLE);
  assign done             = done_reg;
  assign err              = err_reg;
  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_data  = fifo_empty ? '0 : head[DATA_W-1:0];
  assign out_if.out_last  = !fifo_empty && head[DATA_W];
endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Scoreboard bench: scans are modelled as modulo-DEPTH runs over the ROM table,
// and a negedge monitor pops and compares every transferred word.
module tb_rom_scan_ctrl;
  localparam int DEPTH = 11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] start_addr = '0;
  logic [7:0] count = '0;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic       busy, done, err;

  rom_scan_if #(.DATA_W(8)) sif ();

  rom_scan_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .out_if     (sif)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [256];
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'hEE;
    rom[0] = 90;  rom[1] = 80; rom[2] = 70; rom[3] = 60; rom[4] = 50;  rom[5] = 40;
    rom[6] = 30;  rom[7] = 20; rom[8] = 10; rom[9] = 100; rom[10] = 101;
  end
  always @(posedge clk) rom_data <= rom[rom_addr];

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;
  int err_seen  = 0;
  int n_xfer    = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: stalled, 3: toggling
  logic [8:0] sb [$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    sif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       sif.out_ready = 1'b1;
        1:       sif.out_ready = 1'($urandom_range(0, 1));
        2:       sif.out_ready = 1'b0;
        default: sif.out_ready = ~sif.out_ready;
      endcase
    end
  end

  // Monitor: transfers, hold-under-backpressure, done/err pulses.
  initial begin
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 1'b0;
    logic [8:0] exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", int'(sif.out_valid), 1);
          check("hold_data", int'(sif.out_data), int'(prev_data));
          check("hold_last", int'(sif.out_last), int'(prev_last));
        end
        if (sif.out_valid && sif.out_ready) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: got %0d expected no word", sif.out_data);
          end else begin
            exp = sb.pop_front();
            check("word_data", int'(sif.out_data), int'(exp[7:0]));
            check("word_last", int'(sif.out_last), int'(exp[8]));
          end
          n_xfer++;
          $display("[TB] xfer data=%0d last=%0d", sif.out_data, sif.out_last);
        end
        if (done) done_seen++;
        if (err)  err_seen++;
        prev_stall = sif.out_valid && !sif.out_ready;
        prev_data  = sif.out_data;
        prev_last  = sif.out_last;
      end
    end
  end

  // Returns one ns after the edge that samples start (E0).
  task automatic do_start(input int sa, input int cnt);
    int guard = 0;
    while (busy && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("idle_before_start", int'(busy), 0);
    @(posedge clk);
    #1;
    start = 1'b1;
    start_addr = 8'(sa);
    count = 8'(cnt);
    if (sa < DEPTH)
      for (int i = 0; i < cnt; i++)
        sb.push_back({(i == cnt - 1), rom[(sa + i) % DEPTH]});
    $display("[TB] start addr=%0d count=%0d", sa, cnt);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input bit want_err);
    int d0 = done_seen;
    int e0 = err_seen;
    int cyc = 0;
    while (done_seen == d0 && err_seen == e0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("end_in_time", int'(cyc < 3000), 1);
    check("end_err_pulses", err_seen - e0, want_err ? 1 : 0);
    check("end_done_pulses", done_seen - d0, want_err ? 0 : 1);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #(500000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int x0;
    int sa;
    int cnt;
    repeat (3) @(posedge clk);
    #2;
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_valid", int'(sif.out_valid), 0);
    check("rst_data", int'(sif.out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;

    // Basic run with latency and done timing.
    ready_mode = 0;
    do_start(0, 3);
    check("t1_addr", int'(rom_addr), 0);
    check("t1_valid_e0", int'(sif.out_valid), 0);
    @(posedge clk); #1;
    check("t1_valid_e1", int'(sif.out_valid), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("t1_valid", int'(sif.out_valid), 1);
      check("t1_data", int'(sif.out_data), int'(rom[k]));
      check("t1_last", int'(sif.out_last), (k == 2) ? 1 : 0);
    end
    @(posedge clk); #1;
    check("t1_done", int'(done), 1);
    check("t1_busy", int'(busy), 0);
    wait_end(0);

    // Address wrap.
    do_start(9, 4);
    for (int k = 0; k < 4; k++) begin
      check("t2_rom_addr", int'(rom_addr), (9 + k) % DEPTH);
      @(posedge clk); #1;
    end
    wait_end(0);

    // Backpressure: only FIFO_D reads may be outstanding while stalled.
    ready_mode = 2;
    do_start(2, 8);
    repeat (5) @(posedge clk);
    #1;
    check("t3_issue_limit", int'(rom_addr), (2 + 3) % DEPTH);
    check("t3_valid", int'(sif.out_valid), 1);
    ready_mode = 3;
    wait_end(0);
    ready_mode = 0;

    // Zero count, then out-of-range start.
    do_start(4, 0);
    check("t4_done", int'(done), 1);
    check("t4_busy", int'(busy), 0);
    wait_end(0);
    a0 = int'(rom_addr);
    do_start(11, 5);
    check("t4_err", int'(err), 1);
    check("t4_rom_addr", int'(rom_addr), a0);
    wait_end(1);

    // start while busy is ignored.
    ready_mode = 1;
    do_start(3, 6);
    @(posedge clk); #1;
    check("t5_busy", int'(busy), 1);
    start = 1'b1; start_addr = 8'd0; count = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_end(0);
    do_start(7, 3);
    wait_end(0);

    // Reset in the middle of a scan.
    ready_mode = 0;
    x0 = n_xfer;
    do_start(0, 8);
    for (int g = 0; g < 100 && n_xfer < x0 + 2; g++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", int'(sif.out_valid), 0);
    check("t6_rst_data", int'(sif.out_data), 0);
    check("t6_rst_last", int'(sif.out_last), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_addr", int'(rom_addr), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_start(5, 2);
    wait_end(0);

    // Randomized scans.
    for (int r = 0; r < 20; r++) begin
      sa  = int'($urandom_range(0, 12));
      cnt = int'($urandom_range(0, 24));
      ready_mode = ($urandom_range(0, 2) == 2) ? 3 : int'($urandom_range(0, 1));
      do_start(sa, cnt);
      wait_end(sa >= DEPTH);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
